// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - round-robin scheduler sharing one loadable up/down counter
module counter_sched #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_start,
  input  logic [NREQ*W-1:0] req_target,
  input  logic [NREQ-1:0]   req_dir,
  input  logic              abort,
  output logic [NREQ-1:0]   done,
  output logic              aborted,
  output logic              busy,
  output logic [GW-1:0]     gnt_id,
  output logic              cnt_reset,
  output logic              cnt_load,
  output logic              cnt_up_down,
  output logic [W-1:0]      cnt_data,
  input  logic [W-1:0]      cnt_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] gnt_id_q, gnt_id_d;
  logic [W-1:0]  job_start_q, job_start_d;
  logic [W-1:0]  job_target_q, job_target_d;
  logic          job_dir_q, job_dir_d;
  logic          aborted_q, aborted_d;

  logic [W-1:0]  start_arr  [NREQ];
  logic [W-1:0]  target_arr [NREQ];
  logic [GW:0]   sum;
  logic [GW-1:0] win;
  logic          found;
  logic [GW-1:0] next_ptr;

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign start_arr[g]  = req_start[g*W +: W];
    assign target_arr[g] = req_target[g*W +: W];
  end

  // First requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int j = 0; j < NREQ; j++) begin
      sum = {1'b0, rr_ptr_q} + (GW+1)'(j);
      if (sum >= (GW+1)'(NREQ)) sum = sum - (GW+1)'(NREQ);
      if (!found && req[sum[GW-1:0]]) begin
        found = 1'b1;
        win   = sum[GW-1:0];
      end
    end
  end

  assign next_ptr = (gnt_id_q == GW'(NREQ-1)) ? '0 : gnt_id_q + GW'(1);

  // Counter has no enable: "hold" is a load of its own current value.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_id_d     = gnt_id_q;
    job_start_d  = job_start_q;
    job_target_d = job_target_q;
    job_dir_d    = job_dir_q;
    aborted_d    = 1'b0;
    cnt_load     = 1'b1;
    cnt_data     = cnt_count;
    cnt_up_down  = job_dir_q;
    done         = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_id_d     = win;
          job_start_d  = start_arr[win];
          job_target_d = target_arr[win];
          job_dir_d    = req_dir[win];
          state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          aborted_d = 1'b1;
          rr_ptr_d  = next_ptr;
          state_d   = S_IDLE;
        end else begin
          cnt_data = job_start_q;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          aborted_d = 1'b1;
          rr_ptr_d  = next_ptr;
          state_d   = S_IDLE;
        end else if (cnt_count == job_target_q) begin
          state_d = S_DONE;
        end else begin
          cnt_load = 1'b0;
        end
      end
      default: begin
        done[gnt_id_q] = 1'b1;
        rr_ptr_d       = next_ptr;
        state_d        = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      gnt_id_q     <= '0;
      job_start_q  <= '0;
      job_target_q <= '0;
      job_dir_q    <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_id_q     <= gnt_id_d;
      job_start_q  <= job_start_d;
      job_target_q <= job_target_d;
      job_dir_q    <= job_dir_d;
      aborted_q    <= aborted_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign aborted   = aborted_q;
  assign gnt_id    = gnt_id_q;
  assign cnt_reset = reset;

endmodule

// File: tb/tb_counter_sched.sv
// tb/tb_counter_sched.sv - bench for counter_sched with a job-level reference model
module tb_counter_sched;

  logic        clk;
  logic        reset;
  logic        abort;
  logic [3:0]  req;
  logic [3:0]  req_dir;
  logic [15:0] req_start;
  logic [15:0] req_target;
  logic [3:0]  done;
  logic        aborted;
  logic        busy;
  logic [1:0]  gnt_id;
  logic        cnt_reset;
  logic        cnt_load;
  logic        cnt_up_down;
  logic [3:0]  cnt_data;
  logic [3:0]  cnt_q;

  int checks   = 0;
  int failures = 0;

  bit         req_r    [4];
  logic [3:0] j_start  [4];
  logic [3:0] j_target [4];
  bit         j_dir    [4];

  bit         m_known = 1'b0;
  bit         m_busy, m_dir, m_ab;
  int         m_t, m_k, m_owner, m_ptr, m_last, m_fin;
  logic [3:0] m_start, m_target, m_hold;

  int up_cnt [9] = '{0, 0, 3, 4, 5, 6, 7, 7, 7};
  int dn_cnt [9] = '{7, 7, 2, 1, 0, 15, 14, 14, 14};
  int rr_gnt [5] = '{0, 1, 2, 3, 0};
  int rr_cyc [5] = '{1, 6, 11, 16, 21};

  counter_sched dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_start   (req_start),
    .req_target  (req_target),
    .req_dir     (req_dir),
    .abort       (abort),
    .done        (done),
    .aborted     (aborted),
    .busy        (busy),
    .gnt_id      (gnt_id),
    .cnt_reset   (cnt_reset),
    .cnt_load    (cnt_load),
    .cnt_up_down (cnt_up_down),
    .cnt_data    (cnt_data),
    .cnt_count   (cnt_q)
  );

  // The shared counter the scheduler drives.
  always_ff @(posedge clk) begin
    if (cnt_reset)        cnt_q <= 4'd0;
    else if (cnt_load)    cnt_q <= cnt_data;
    else if (cnt_up_down) cnt_q <= cnt_q + 4'd1;
    else                  cnt_q <= cnt_q - 4'd1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_job(input int i, input int s, input int t, input int d);
    j_start[i]  = 4'(s);
    j_target[i] = 4'(t);
    j_dir[i]    = d[0];
    req_r[i]    = 1'b1;
  endtask

  // Counter value implied by the job timeline: start, then one step per RUN cycle.
  function automatic logic [3:0] exp_count();
    if (!m_busy || m_t == 1) return m_hold;
    if (m_t <= 2 + m_k) return m_dir ? 4'(m_start + 4'(m_t - 2)) : 4'(m_start - 4'(m_t - 2));
    return m_target;
  endfunction

  task automatic model_compare();
    int         ph;
    bit         step;
    logic [3:0] ec, ed, eo;
    chk("cnt_reset", cnt_reset, reset);
    if (m_known && !reset) begin
      ph   = !m_busy ? 0 : (m_t == 1) ? 1 : (m_t <= 2 + m_k) ? 2 : 3;
      ec   = exp_count();
      step = (ph == 2) && (m_t < 2 + m_k) && !abort;
      ed   = (ph == 1 && !abort) ? m_start : ec;
      eo   = (ph == 3) ? 4'(1 << m_owner) : 4'd0;
      chk("busy", busy, ph != 0);
      chk("gnt_id", gnt_id, m_last);
      chk("aborted", aborted, m_ab);
      chk("done", done, eo);
      chk("cnt_count", cnt_q, ec);
      chk("cnt_load", cnt_load, !step);
      if (!step) chk("cnt_data", cnt_data, ed);
      else       chk("cnt_up_down", cnt_up_down, m_dir);
    end
  endtask

  task automatic model_update();
    bit fnd;
    m_fin = -1;
    if (reset) begin
      m_known = 1'b1;
      m_busy  = 1'b0;
      m_ab    = 1'b0;
      m_ptr   = 0;
      m_last  = 0;
      m_hold  = 4'd0;
    end else if (m_known) begin
      m_ab = 1'b0;
      if (!m_busy) begin
        fnd = 1'b0;
        for (int j = 0; j < 4; j++) begin
          if (!fnd && req_r[(m_ptr + j) % 4]) begin
            fnd     = 1'b1;
            m_owner = (m_ptr + j) % 4;
          end
        end
        if (fnd) begin
          m_busy   = 1'b1;
          m_t      = 1;
          m_start  = j_start[m_owner];
          m_target = j_target[m_owner];
          m_dir    = j_dir[m_owner];
          m_k      = m_dir ? int'(4'(m_target - m_start)) : int'(4'(m_start - m_target));
          m_last   = m_owner;
        end
      end else if (abort && m_t <= 2 + m_k) begin
        m_hold = exp_count();
        m_busy = 1'b0;
        m_ab   = 1'b1;
        m_ptr  = (m_owner + 1) % 4;
      end else if (m_t == 3 + m_k) begin
        m_hold = m_target;
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % 4;
        m_fin  = m_owner;
      end else begin
        m_t++;
      end
    end
  endtask

  task automatic pre();
    for (int i = 0; i < 4; i++) begin
      req[i]             = req_r[i];
      req_dir[i]         = j_dir[i];
      req_start[i*4 +: 4]  = j_start[i];
      req_target[i*4 +: 4] = j_target[i];
    end
    #1;
    model_compare();
  endtask

  task automatic post();
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (m_fin >= 0) req_r[m_fin] = 1'b0;
  endtask

  initial begin
    int  ng;
    bit  pb;
    int  gl [5];
    int  gc [5];
    bit  rera;
    reset = 1'b1;
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_r[i] = 1'b0; j_start[i] = 4'd0; j_target[i] = 4'd0; j_dir[i] = 1'b0;
    end
    @(negedge clk);

    pre(); post();
    pre();
    chk("rst_cnt_reset", cnt_reset, 1'b1);
    chk("rst_cnt", cnt_q, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 4'd0);
    post();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      pre(); chk("idle_cnt", cnt_q, 4'd0); post();
    end

    set_job(1, 3, 7, 1);
    for (int c = 0; c < 9; c++) begin
      pre();
      chk("up_cnt", cnt_q, up_cnt[c]);
      chk("up_done", done, (c == 7) ? 4'b0010 : 4'b0000);
      if (c == 1) chk("up_gnt", gnt_id, 2'd1);
      post();
    end

    set_job(0, 2, 14, 0);
    for (int c = 0; c < 9; c++) begin
      pre();
      chk("dn_cnt", cnt_q, dn_cnt[c]);
      chk("dn_done", done, (c == 7) ? 4'b0001 : 4'b0000);
      if (c == 8) chk("dn_busy", busy, 1'b0);
      post();
    end

    set_job(2, 9, 9, 1);
    for (int c = 0; c < 5; c++) begin
      pre();
      chk("z_cnt", cnt_q, (c < 2) ? 4'd14 : 4'd9);
      chk("z_done", done, (c == 3) ? 4'b0100 : 4'b0000);
      chk("z_busy", busy, (c >= 1 && c <= 3));
      post();
    end

    reset = 1'b1;
    pre(); post(); pre(); post();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_job(i, i, i + 1, 1);
    ng = 0; pb = 1'b0; rera = 1'b0;
    for (int c = 0; c < 27; c++) begin
      pre();
      if (busy && !pb && ng < 5) begin
        gl[ng] = gnt_id; gc[ng] = c; ng++;
      end
      pb = busy;
      post();
      if (!req_r[0] && !rera) begin
        set_job(0, 5, 6, 1);
        rera = 1'b1;
      end
    end
    chk("rr_count", ng, 5);
    for (int i = 0; i < 5 && i < ng; i++) begin
      chk("rr_gnt", gl[i], rr_gnt[i]);
      chk("rr_cycle", gc[i], rr_cyc[i]);
    end

    set_job(2, 3, 10, 1);
    for (int c = 0; c < 10; c++) begin
      abort = (c == 4);
      if (c == 5) set_job(1, 0, 0, 1);
      if (c == 6) req_r[2] = 1'b0;
      pre();
      if (c == 4) chk("ab_cnt5", cnt_q, 4'd5);
      if (c <= 5) chk("ab_nodone", done, 4'd0);
      if (c == 5) begin
        chk("ab_pulse", aborted, 1'b1);
        chk("ab_busy", busy, 1'b0);
        chk("ab_hold", cnt_q, 4'd5);
      end
      if (c == 6) chk("ab_skip_gnt", gnt_id, 2'd1);
      if (c == 8) chk("ab_next_done", done, 4'b0010);
      post();
    end
    abort = 1'b0;

    set_job(3, 3, 10, 1);
    for (int c = 0; c < 5; c++) begin
      reset = (c == 4);
      pre();
      if (c == 4) chk("mr_cnt5", cnt_q, 4'd5);
      post();
    end
    reset = 1'b0;
    req_r[3] = 1'b0;
    pre();
    chk("mr_busy", busy, 1'b0);
    chk("mr_cnt", cnt_q, 4'd0);
    chk("mr_gnt", gnt_id, 2'd0);
    post();

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++)
        if (!req_r[i] && $urandom_range(0, 3) == 0)
          set_job(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
      if (m_busy && $urandom_range(0, 19) == 0) req_r[m_owner] = 1'b0;
      abort = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 299) == 0);
      pre();
      post();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_sched.md
# counter_sched

Round-robin scheduler that shares one 4-bit loadable up/down counter among `NREQ` requesters. Each requester asks for a counting job: load a start value, count in a given direction, stop at a target value. The block grants one job at a time, drives the counter's reset/load/up_down/data controls, watches its `count` output to detect completion, and returns a one-cycle `done` pulse to the owner. It sits between the requesting logic and the counter instance.

## Interface
- `NREQ`, 4: number of requesters; must be at least 2.
- `W`, 4: counter width; matches the counter's `data`/`count` width.
- `clk` in 1: single clock; everything is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req` in NREQ: per-requester job request, level. Hold it high until the matching `done` or `aborted`.
- `req_start` in NREQ*W: start value; slice i is bits [i*W +: W].
- `req_target` in NREQ*W: stop value; slice i is bits [i*W +: W].
- `req_dir` in NREQ: 1 = count up, 0 = count down.
- `abort` in 1: terminate the current job.
- `done` out NREQ: one-hot, one-cycle completion pulse to the job owner.
- `aborted` out 1: one-cycle pulse confirming an abort.
- `busy` out 1: high while a job is granted (states LOAD, RUN, DONE).
- `gnt_id` out $clog2(NREQ): index of the current or last owner.
- `cnt_reset` out 1: drives the counter's `reset`; equals `reset` combinationally.
- `cnt_load`, `cnt_up_down` out 1: drive the counter's `load` and `up_down`.
- `cnt_data` out W: drives the counter's `data`.
- `cnt_count` in W: the counter's `count` output.

## Operation
- The counter has no enable; it steps every cycle it is not loaded. The scheduler holds it by driving `cnt_load`=1 with `cnt_data`=`cnt_count`. This is called "hold" below.
- FSM states: IDLE, LOAD, RUN, DONE. The state register and latched job fields are registered. Counter controls and `done` are decoded combinationally from state and `cnt_count`.
- IDLE:
  - Drive hold.
  - If any `req` bit is high, pick the winner: the first set bit searching from `rr_ptr` upward, wrapping modulo NREQ.
  - Latch the winner's start, target, dir and index into `job_*` and `gnt_id`, then go to LOAD.
- LOAD: drive `cnt_load`=1, `cnt_data`=`job_start`, then go to RUN.
- RUN:
  - If `cnt_count`==`job_target`: drive hold, go to DONE.
  - Otherwise drive `cnt_load`=0, `cnt_up_down`=`job_dir`.
- DONE:
  - Drive hold and `done[gnt_id]`=1.
  - Set `rr_ptr` = (`gnt_id`+1) mod NREQ, then go to IDLE.
- Arithmetic is modulo 2^W; every target is reachable.
  - Steps k = (target−start) mod 16 when counting up, or (start−target) mod 16 when counting down.
  - k=0 (start==target) completes with no counting.
- Abort:
  - In LOAD or RUN, `abort`=1 drives hold that cycle and sends the FSM to IDLE.
  - `aborted` pulses in the next cycle (registered), `done` is not asserted, and `rr_ptr` advances past `gnt_id`.
  - `abort` is ignored in IDLE and DONE.
  - If `abort` and a target match occur in the same RUN cycle, abort wins.
- Dropping `req` mid-job does not cancel the job. It completes normally, and `done` still pulses.
- Reset, including mid-job:
  - Next state is IDLE; `rr_ptr`=0, `gnt_id`=0, `aborted`=0; `busy`=0 and `done`=0 follow from IDLE.
  - `cnt_reset`=1 clears the counter to 0.

## Timing
- Let cycle 0 be the IDLE cycle in which `req` is sampled.
- LOAD is cycle 1. `cnt_count`=start in cycle 2, the first RUN cycle.
- RUN lasts k+1 cycles; `cnt_count` reaches target in cycle 2+k.
- DONE, with the `done` pulse, is cycle 3+k. IDLE returns in cycle 4+k, where the next grant may be sampled.
- After DONE, the counter holds target until the next LOAD.
- The abort-sample cycle is the last cycle of the job. `aborted` is high the following cycle, which is IDLE.

## Test plan
- Reset: `reset` high for 2 cycles → `cnt_reset`=1, `cnt_count`=0, `busy`=0, `done`=0. After release, `cnt_count` holds at 0 for 10 idle cycles.
- Up job: requester 1, start=3, target=7, dir=1 → `gnt_id`=1, count 3,4,5,6,7. `done`=4'b0010 exactly 7 cycles after sampling; count then holds 7.
- Down wrap: requester 0, start=2, target=14, dir=0 → count 2,1,0,15,14; `done[0]` at cycle 7; `busy` low in cycle 8.
- Zero length: requester 2, start=target=9 → one RUN cycle, `done[2]` at cycle 3, count stays 9.
- Round robin: all four `req` held with distinct jobs → grant order 0,1,2,3,0. No gap cycles other than the IDLE cycle between jobs.
- Abort: job 3→10 up; assert `abort` when `cnt_count`=5 → count stays 5, `aborted` pulses next cycle, no `done`, next grant skips the aborted requester. Then repeat with `reset` asserted mid-RUN → FSM returns to IDLE and count=0.
